// File: rtl/mant_div24_pkg.sv
// ----------------------------------------------------------------------------
// mant_div_pkg : shared types and constants for the mantissa divider
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mant_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  localparam int DIV_W     = 24;
  localparam int DIV_QBITS = DIV_W + 1;
  localparam logic [DIV_QBITS-1:0] DIV_DZ_RESULT = '1;

endpackage

`default_nettype wire

// File: rtl/mant_div24_step.sv
// ----------------------------------------------------------------------------
// mant_div_step : one restoring-division iteration (compare, subtract, shift)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mant_div_step
  import mant_div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH+1:0] rem,
  input  logic [WIDTH:0]   div,
  output logic [WIDTH+1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH+2:0] w_diff;
  logic [WIDTH+1:0] w_sel;

  assign w_diff   = {1'b0, rem} - {2'b00, div};
  assign qbit     = ~w_diff[WIDTH+2];
  assign w_sel    = qbit ? w_diff[WIDTH+1:0] : rem;
  assign rem_next = w_sel << 1;

endmodule

`default_nettype wire

// File: rtl/mant_div24.sv
// ----------------------------------------------------------------------------
// mant_div24 : iterative restoring divider, R = floor((A << 23) / B), 2.23
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mant_div24
  import mant_div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH:0]   R,
  output logic             STICKY,
  output logic             DZ
);

  localparam int QBITS = WIDTH + 1;
  localparam int CNT_W = $clog2(QBITS);

  div_state_t         r_state;
  logic [WIDTH+1:0]   r_rem;
  logic [WIDTH:0]     r_div;
  logic [QBITS-1:0]   r_q;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [QBITS-1:0]   r_r;
  logic               r_sticky;
  logic               r_dz;

  logic [WIDTH+1:0]   w_rem_next;
  logic               w_qbit;

  // Comparing against 2B gives the first quotient bit a weight of 2^24,
  // which is what places the result in 2.23 format.
  mant_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_rem),
    .div      (r_div),
    .rem_next (w_rem_next),
    .qbit     (w_qbit)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_div    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_r      <= '0;
      r_sticky <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // BUSY stays high through the DONE cycle, so a restart waits one more cycle
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (START) begin
            r_div   <= {B, 1'b0};
            r_rem   <= {2'b00, A};
            r_q     <= '0;
            r_cnt   <= CNT_W'(QBITS - 1);
            r_busy  <= 1'b1;
            r_state <= (B == '0) ? FIN : CALC;
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[QBITS-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= FIN;
        end
        FIN: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
          if (r_div == '0) begin
            r_r      <= '1;
            r_sticky <= 1'b0;
            r_dz     <= 1'b1;
          end else begin
            r_r      <= r_q;
            r_sticky <= |r_rem;
            r_dz     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign R      = r_r;
  assign STICKY = r_sticky;
  assign DZ     = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_mant_div24.sv
// ----------------------------------------------------------------------------
// tb_mant_div24 : directed + random checks of mant_div24 against a cycle model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mant_div24;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [23:0] A;
  logic [23:0] B;
  logic        BUSY;
  logic        DONE;
  logic [24:0] R;
  logic        STICKY;
  logic        DZ;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  mant_div24 dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .R      (R),
    .STICKY (STICKY),
    .DZ     (DZ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [24:0] f_quot(input logic [23:0] a, input logic [23:0] b);
    logic [63:0] n;
    n = {40'd0, a} << 23;
    if (b == 24'd0) return '1;
    return 25'(n / {40'd0, b});
  endfunction

  function automatic logic f_sticky(input logic [23:0] a, input logic [23:0] b);
    logic [63:0] n;
    n = {40'd0, a} << 23;
    if (b == 24'd0) return 1'b0;
    return (n % {40'd0, b}) != 64'd0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: accept when idle, result appears after a fixed latency
  logic        m_busy, m_done, m_st, m_dz, p_st, p_dz;
  logic [24:0] m_r, p_r;
  int          m_cnt;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
      m_r <= '0; m_st <= 1'b0; m_dz <= 1'b0;
      p_r <= '0; p_st <= 1'b0; p_dz <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_r    <= p_r;
        m_st   <= p_st;
        m_dz   <= p_dz;
      end
      m_cnt <= m_cnt - 1;
    end else if (START) begin
      m_busy <= 1'b1;
      m_cnt  <= (B == 24'd0) ? 1 : 26;
      p_r    <= f_quot(A, B);
      p_st   <= f_sticky(A, B);
      p_dz   <= (B == 24'd0);
    end
  end

  always @(negedge CLK) begin
    chk("busy",   BUSY,   m_busy);
    chk("done",   DONE,   m_done);
    chk("r",      R,      m_r);
    chk("sticky", STICKY, m_st);
    chk("dz",     DZ,     m_dz);
    if (DONE) done_cnt++;
  end

  task automatic start_op(input logic [23:0] a, input logic [23:0] b);
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int lat);
    ok = 1'b0; lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE) begin ok = 1'b1; lat = i + 1; break; end
    end
  endtask

  task automatic do_case(input string name, input logic [23:0] a, input logic [23:0] b,
                         input logic [24:0] er, input logic est, input logic edz,
                         input int elat, input bit pin);
    bit ok; int lat;
    start_op(a, b);
    wait_done(ok, lat);
    chk({name, "_timeout"}, ok, 1);
    chk({name, "_lat"}, lat, elat);
    chk({name, "_R"}, R, er);
    chk({name, "_STICKY"}, STICKY, est);
    chk({name, "_DZ"}, DZ, edz);
    if (pin) chk({name, "_model"}, m_r, er);
    @(negedge CLK);
  endtask

  initial begin
    bit ok; int lat; int dc0;
    logic [23:0] ra, rb;
    RESET = 1'b0; START = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_R", R, 0);
    RESET = 1'b1;

    do_case("c1",   24'h800000, 24'h800000, 25'h0800000, 1'b0, 1'b0, 26, 1);
    do_case("c2a",  24'hC00000, 24'h800000, 25'h0C00000, 1'b0, 1'b0, 26, 1);
    do_case("c2b",  24'hFFFFFF, 24'h800000, 25'h0FFFFFF, 1'b0, 1'b0, 26, 1);
    do_case("c3a",  24'h800000, 24'hC00000, 25'h0555555, 1'b1, 1'b0, 26, 1);
    do_case("c3b",  24'h800000, 24'hFFFFFF, 25'h0400000, 1'b1, 1'b0, 26, 1);
    do_case("c4dz", 24'h900000, 24'h000000, 25'h1FFFFFF, 1'b0, 1'b1, 1,  1);
    do_case("c4nx", 24'hC00000, 24'h800000, 25'h0C00000, 1'b0, 1'b0, 26, 1);
    do_case("a0",   24'h000000, 24'hABCDEF, 25'h0000000, 1'b0, 1'b0, 26, 1);

    // START pulses at edges 5 and 12 must not disturb the running division
    dc0 = done_cnt;
    start_op(24'h800000, 24'h800000);
    repeat (3) @(negedge CLK);
    A = 24'hFFFFFF; B = 24'h000000; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (6) @(negedge CLK);
    A = 24'h900000; B = 24'hC00000; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    wait_done(ok, lat);
    chk("c5_timeout", ok, 1);
    chk("c5_R", R, 25'h0800000);
    repeat (5) @(negedge CLK);
    chk("c5_one_done", done_cnt - dc0, 1);

    // Asynchronous reset in the middle of a division
    start_op(24'hC00000, 24'h800000);
    repeat (10) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    chk("c6_busy", BUSY, 0);
    chk("c6_done", DONE, 0);
    chk("c6_R", R, 0);
    @(negedge CLK);
    RESET = 1'b1;
    dc0 = done_cnt;
    repeat (30) @(negedge CLK);
    chk("c6_no_done", done_cnt - dc0, 0);
    do_case("c6_after", 24'h800000, 24'hC00000, 25'h0555555, 1'b1, 1'b0, 26, 1);

    for (int i = 0; i < 300; i++) begin
      ra = 24'h800000 | 24'($urandom_range(24'h7FFFFF, 0));
      rb = 24'h800000 | 24'($urandom_range(24'h7FFFFF, 0));
      if (i % 50 == 7) ra = 24'h000000;
      do_case("rnd", ra, rb, f_quot(ra, rb), f_sticky(ra, rb), 1'b0, 26, 0);
    end

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
